ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register with valid/ready flow control, a 2-entry skid buffer, flush and bubble insertion.
//  Sits between the EX stage (ALU/branch target) and MEM stage (data memory, branch resolve).
//  Stalls the pipeline without dropping data. Presents a registered forwarding tap to the hazard unit.
// PARAMETERS
//  DATA_W   32  width of ALU result, store data and branch destination
//  REG_AW   5   register-file address width (Write_Register, Rd)
//  INSTR_W  32  instruction width; Rd is taken from bits [REG_AW+10:11]
// PORTS
//  Clk                 in   1        rising-edge clock
//  Rst_n               in   1        asynchronous, active-low reset
//  Flush               in   1        kill all held entries (branch taken / exception)
//  ex_valid            in   1        EX payload valid
//  ex_ready            out  1        stage can accept EX payload (registered)
//  Ctrl_EX             in   5        {RegWrite,MemtoReg,Branch,MemRead,MemWrite}
//  Zero_EX             in   1        ALU zero flag
//  Branch_Dest_EX      in   DATA_W   branch target
//  ALU_Result_EX       in   DATA_W   ALU result / memory address
//  Read_Data_2_EX      in   DATA_W   store data
//  Write_Register_EX   in   REG_AW   destination register
//  Instruction_EX      in   INSTR_W  EX instruction
//  mem_valid           out  1        MEM payload valid
//  mem_ready           in   1        MEM stage accepts payload
//  Ctrl_MEM            out  5        control; forced 0 when !mem_valid
//  Zero_MEM, Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM, Write_Register_MEM, Instruction_Rd_MEM  out  as EX side
//  Fwd_En              out  1        mem_valid & RegWrite & Write_Register_MEM!=0
//  Fwd_Reg             out  REG_AW   = Write_Register_MEM
//  Fwd_Data            out  DATA_W   = ALU_Result_MEM
// BEHAVIOUR
//  Reset (Rst_n=0, async): main_v=0, skid_v=0, ex_ready=1, mem_valid=0, all payload/output regs 0, Fwd_En=0.
//  Storage: main register (drives MEM outputs) plus skid register. ex_ready = !skid_v, registered.
//  States: EMPTY(main_v=0), ONE(main_v=1,skid_v=0), TWO(both 1). Per rising edge, with acc=ex_valid&ex_ready and pop=mem_valid&mem_ready:
//   EMPTY: acc -> ONE (payload to main).
//   ONE: acc&!pop -> TWO (payload to skid). acc&pop -> ONE (main reloaded). !acc&pop -> EMPTY.
//   TWO: pop -> ONE (skid moves to main; ex_ready=1 next cycle). !pop -> hold.
//  Latency: 1 cycle EX->MEM when unstalled. Full throughput when mem_ready=1.
//  Bubble: when !mem_valid, Ctrl_MEM=0 and Fwd_En=0. Data outputs hold their last value and are don't-care.
//  Flush has priority: next state EMPTY. Any same-cycle acc is discarded. ex_ready=1 next cycle. A same-cycle pop still counts as consumed.
//  Simultaneous pop and acc in TWO cannot occur (ex_ready=0).
//  Instruction_Rd_MEM = Instruction_EX[REG_AW+10:11], captured with the payload.
//  No arithmetic. All widths pass through unchanged and payload is never modified.
// CONFIGURATION
//  EX_MEM_TRACE_EN defined: adds outputs Instruction_MEM[INSTR_W] and Trace_Seq[16].
//   Trace_Seq increments by 1 per pop, wraps 16'hFFFF->0, is reset to 0 and is unaffected by Flush.
//  Not defined: ports and trace logic absent. Only Rd is stored.
// STRUCTURE
//  Package ex_mem_pkg: CTRL_W=5, bit indices CTRL_REGWRITE=4, CTRL_MEMTOREG=3, CTRL_BRANCH=2, CTRL_MEMREAD=1, CTRL_MEMWRITE=0, state encoding localparams.
//  One sub-module: ex_mem_skid_slot (payload register with load/clear). Instantiated twice (main, skid).
// TESTING
//  Reset mid-TWO (assert Rst_n=0 async) -> mem_valid=0, ex_ready=1, Ctrl_MEM=0 immediately, without waiting for a clock edge.
//  Stream 8 items, ALU_Result 1..8, mem_ready=1 -> appear in order, 1 per cycle, 1-cycle latency.
//  mem_ready=0 while sending A=0x10,B=0x20,C=0x30 -> A held, B in skid, ex_ready=0, C not accepted.
//   Then mem_ready=1 -> A, B, C delivered in order, none lost.
//  Flush in TWO with ex_valid=1 (payload 0x55) -> next cycle mem_valid=0, Ctrl_MEM=0, 0x55 never appears.
//  Ctrl_EX=5'b10000, Write_Register_EX=0 -> Fwd_En=0. With Write_Register_EX=5 -> Fwd_En=1, Fwd_Reg=5.
//  EX_MEM_TRACE_EN: 3 pops -> Trace_Seq=3. A flush -> Trace_Seq unchanged. Instruction_MEM equals the captured instruction.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared constants for the EX->MEM pipeline register: control-bit layout and occupancy states.
package ex_mem_pkg;

    localparam int CTRL_W        = 5;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMWRITE = 0;

    // Encoding is {skid_v, main_v}, so the slot valid flags are the state register.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_t;

endpackage

// File: rtl/ex_mem_skid_slot.sv
// One payload slot of the EX->MEM register: valid flag plus data, with load and clear.
module ex_mem_skid_slot
    import ex_mem_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // Clear only drops the valid flag; the data keeps its last value.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= d;
        end
    end

    assign valid = valid_reg;
    assign q     = data_reg;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, 2-entry skid, flush and forwarding tap.
// Define EX_MEM_TRACE_EN to add Instruction_MEM and the Trace_Seq pop counter.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int INSTR_W = 32
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [CTRL_W-1:0]  Ctrl_EX,
    input  logic               Zero_EX,
    input  logic [DATA_W-1:0]  Branch_Dest_EX,
    input  logic [DATA_W-1:0]  ALU_Result_EX,
    input  logic [DATA_W-1:0]  Read_Data_2_EX,
    input  logic [REG_AW-1:0]  Write_Register_EX,
    input  logic [INSTR_W-1:0] Instruction_EX,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [CTRL_W-1:0]  Ctrl_MEM,
    output logic               Zero_MEM,
    output logic [DATA_W-1:0]  Branch_Dest_MEM,
    output logic [DATA_W-1:0]  ALU_Result_MEM,
    output logic [DATA_W-1:0]  Write_Data_MEM,
    output logic [REG_AW-1:0]  Write_Register_MEM,
    output logic [REG_AW-1:0]  Instruction_Rd_MEM,
    output logic               Fwd_En,
    output logic [REG_AW-1:0]  Fwd_Reg,
    output logic [DATA_W-1:0]  Fwd_Data
`ifdef EX_MEM_TRACE_EN
    ,
    output logic [INSTR_W-1:0] Instruction_MEM,
    output logic [15:0]        Trace_Seq
`endif
);

`ifdef EX_MEM_TRACE_EN
    localparam int ISTORE_W = INSTR_W;
`else
    localparam int ISTORE_W = REG_AW;
`endif
    localparam int PAY_W = CTRL_W + 1 + 3 * DATA_W + REG_AW + ISTORE_W;

    logic [ISTORE_W-1:0] ex_instr_store;
    logic [ISTORE_W-1:0] main_instr;
    logic [PAY_W-1:0]    ex_payload;
    logic [CTRL_W-1:0]   main_ctrl;

`ifdef EX_MEM_TRACE_EN
    assign ex_instr_store = Instruction_EX;
`else
    // Only the Rd field is kept; the remaining instruction bits are intentionally dropped.
    assign ex_instr_store = Instruction_EX[REG_AW+10:11];
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instruction_EX[INSTR_W-1:REG_AW+11], Instruction_EX[10:0]};
`endif

    assign ex_payload = {Ctrl_EX, Zero_EX, Branch_Dest_EX, ALU_Result_EX,
                         Read_Data_2_EX, Write_Register_EX, ex_instr_store};

    // Slot 0 is the main register driving MEM, slot 1 is the skid register.
    logic             slot_load  [2];
    logic             slot_clear [2];
    logic             slot_v     [2];
    logic [PAY_W-1:0] slot_d     [2];
    logic [PAY_W-1:0] slot_q     [2];
    logic             main_from_skid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            ex_mem_skid_slot #(.W(PAY_W)) u_slot (
                .Clk   (Clk),
                .Rst_n (Rst_n),
                .load  (slot_load[gi]),
                .clear (slot_clear[gi]),
                .d     (slot_d[gi]),
                .valid (slot_v[gi]),
                .q     (slot_q[gi])
            );
        end
    endgenerate

    assign slot_d[0] = main_from_skid ? slot_q[1] : ex_payload;
    assign slot_d[1] = ex_payload;

    state_t state;
    logic   acc;
    logic   pop;

    assign state     = state_t'({slot_v[1], slot_v[0]});
    assign mem_valid = slot_v[0];
    assign ex_ready  = !slot_v[1];
    assign acc       = ex_valid & ex_ready;
    assign pop       = mem_valid & mem_ready;

    always_comb begin
        slot_load[0]   = 1'b0;
        slot_load[1]   = 1'b0;
        slot_clear[0]  = 1'b0;
        slot_clear[1]  = 1'b0;
        main_from_skid = 1'b0;
        if (Flush) begin
            slot_clear[0] = 1'b1;
            slot_clear[1] = 1'b1;
        end else begin
            case (state)
                S_EMPTY: begin
                    slot_load[0] = acc;
                end
                S_ONE: begin
                    if (acc && !pop) begin
                        slot_load[1] = 1'b1;
                    end else if (acc && pop) begin
                        slot_load[0] = 1'b1;
                    end else if (pop) begin
                        slot_clear[0] = 1'b1;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        slot_load[0]   = 1'b1;
                        main_from_skid = 1'b1;
                        slot_clear[1]  = 1'b1;
                    end
                end
                default: begin
                    slot_clear[0] = 1'b1;
                    slot_clear[1] = 1'b1;
                end
            endcase
        end
    end

    assign {main_ctrl, Zero_MEM, Branch_Dest_MEM, ALU_Result_MEM,
            Write_Data_MEM, Write_Register_MEM, main_instr} = slot_q[0];

    // Bubbles must never look like a register write or memory access downstream.
    assign Ctrl_MEM = mem_valid ? main_ctrl : '0;
    assign Fwd_En   = mem_valid & main_ctrl[CTRL_REGWRITE] & (Write_Register_MEM != '0);
    assign Fwd_Reg  = Write_Register_MEM;
    assign Fwd_Data = ALU_Result_MEM;

`ifdef EX_MEM_TRACE_EN
    assign Instruction_Rd_MEM = main_instr[REG_AW+10:11];
    assign Instruction_MEM    = main_instr;

    logic [15:0] trace_seq_reg;
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            trace_seq_reg <= '0;
        end else if (pop) begin
            trace_seq_reg <= trace_seq_reg + 16'd1;
        end
    end
    assign Trace_Seq = trace_seq_reg;
`else
    assign Instruction_Rd_MEM = main_instr;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Randomized and directed bench for ex_mem_pipe_reg against a 2-deep FIFO reference model.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int INSTR_W = 32;

    logic               Clk;
    logic               Rst_n;
    logic               Flush;
    logic               ex_valid;
    logic               ex_ready;
    logic [4:0]         Ctrl_EX;
    logic               Zero_EX;
    logic [DATA_W-1:0]  Branch_Dest_EX;
    logic [DATA_W-1:0]  ALU_Result_EX;
    logic [DATA_W-1:0]  Read_Data_2_EX;
    logic [REG_AW-1:0]  Write_Register_EX;
    logic [INSTR_W-1:0] Instruction_EX;
    logic               mem_valid;
    logic               mem_ready;
    logic [4:0]         Ctrl_MEM;
    logic               Zero_MEM;
    logic [DATA_W-1:0]  Branch_Dest_MEM;
    logic [DATA_W-1:0]  ALU_Result_MEM;
    logic [DATA_W-1:0]  Write_Data_MEM;
    logic [REG_AW-1:0]  Write_Register_MEM;
    logic [REG_AW-1:0]  Instruction_Rd_MEM;
    logic               Fwd_En;
    logic [REG_AW-1:0]  Fwd_Reg;
    logic [DATA_W-1:0]  Fwd_Data;
`ifdef EX_MEM_TRACE_EN
    logic [INSTR_W-1:0] Instruction_MEM;
    logic [15:0]        Trace_Seq;
`endif

    ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .INSTR_W(INSTR_W)) dut (
        .Clk                (Clk),
        .Rst_n              (Rst_n),
        .Flush              (Flush),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .Ctrl_EX            (Ctrl_EX),
        .Zero_EX            (Zero_EX),
        .Branch_Dest_EX     (Branch_Dest_EX),
        .ALU_Result_EX      (ALU_Result_EX),
        .Read_Data_2_EX     (Read_Data_2_EX),
        .Write_Register_EX  (Write_Register_EX),
        .Instruction_EX     (Instruction_EX),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .Ctrl_MEM           (Ctrl_MEM),
        .Zero_MEM           (Zero_MEM),
        .Branch_Dest_MEM    (Branch_Dest_MEM),
        .ALU_Result_MEM     (ALU_Result_MEM),
        .Write_Data_MEM     (Write_Data_MEM),
        .Write_Register_MEM (Write_Register_MEM),
        .Instruction_Rd_MEM (Instruction_Rd_MEM),
        .Fwd_En             (Fwd_En),
        .Fwd_Reg            (Fwd_Reg),
        .Fwd_Data           (Fwd_Data)
`ifdef EX_MEM_TRACE_EN
        ,
        .Instruction_MEM    (Instruction_MEM),
        .Trace_Seq          (Trace_Seq)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]         ctrl;
        logic               zero;
        logic [DATA_W-1:0]  bd;
        logic [DATA_W-1:0]  alu;
        logic [DATA_W-1:0]  rd2;
        logic [REG_AW-1:0]  wr;
        logic [INSTR_W-1:0] instr;
    } item_t;

    item_t       model_q[$];
    item_t       cur_item;
    logic [31:0] delivered[$];
    int          pops_total;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.ctrl  = 5'($urandom_range(0, 31));
        it.zero  = 1'($urandom_range(0, 1));
        it.bd    = $urandom;
        it.alu   = $urandom;
        it.rd2   = $urandom;
        it.wr    = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
        it.instr = $urandom;
        return it;
    endfunction

    task automatic drive(input item_t it, input logic v, input logic mr, input logic fl);
        cur_item          = it;
        ex_valid          = v;
        mem_ready         = mr;
        Flush             = fl;
        Ctrl_EX           = it.ctrl;
        Zero_EX           = it.zero;
        Branch_Dest_EX    = it.bd;
        ALU_Result_EX     = it.alu;
        Read_Data_2_EX    = it.rd2;
        Write_Register_EX = it.wr;
        Instruction_EX    = it.instr;
    endtask

    task automatic check_outputs();
        item_t f;
        check("mem_valid", mem_valid, model_q.size() > 0);
        check("ex_ready", ex_ready, model_q.size() < 2);
        if (model_q.size() > 0) begin
            f = model_q[0];
            check("ctrl", Ctrl_MEM, f.ctrl);
            check("zero", Zero_MEM, f.zero);
            check("branch_dest", Branch_Dest_MEM, f.bd);
            check("alu", ALU_Result_MEM, f.alu);
            check("write_data", Write_Data_MEM, f.rd2);
            check("write_reg", Write_Register_MEM, f.wr);
            check("instr_rd", Instruction_Rd_MEM, f.instr[REG_AW+10:11]);
            check("fwd_en", Fwd_En, f.ctrl[4] && (f.wr != 0));
            check("fwd_reg", Fwd_Reg, f.wr);
            check("fwd_data", Fwd_Data, f.alu);
`ifdef EX_MEM_TRACE_EN
            check("instr_mem", Instruction_MEM, f.instr);
`endif
        end else begin
            check("ctrl_bubble", Ctrl_MEM, 0);
            check("fwd_bubble", Fwd_En, 0);
        end
`ifdef EX_MEM_TRACE_EN
        check("trace_seq", Trace_Seq, pops_total % 65536);
`endif
    endtask

    // One clock: reference model updates at the edge, outputs are checked on the falling edge.
    task automatic step();
        logic acc;
        logic pop;
        if (mem_valid && mem_ready) delivered.push_back(ALU_Result_MEM);
        @(posedge Clk);
        acc = ex_valid && (model_q.size() < 2);
        pop = (model_q.size() > 0) && mem_ready;
        if (pop) begin
            void'(model_q.pop_front());
            pops_total++;
        end
        if (Flush) model_q.delete();
        else if (acc) model_q.push_back(cur_item);
        @(negedge Clk);
        check_outputs();
    endtask

    initial begin
        item_t it;
        item_t idle;
        logic  seen55;
        n_checks   = 0;
        n_errors   = 0;
        pops_total = 0;
        idle       = '0;
        Rst_n      = 1'b0;
        drive(idle, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_ex_ready", ex_ready, 1);
        check("rst_ctrl", Ctrl_MEM, 0);
        check("rst_fwd_en", Fwd_En, 0);
        check("rst_alu", ALU_Result_MEM, 0);
`ifdef EX_MEM_TRACE_EN
        check("rst_trace", Trace_Seq, 0);
`endif
        Rst_n = 1'b1;
        step();

        // Full-rate stream, one-cycle latency
        for (int k = 1; k <= 8; k++) begin
            it     = rand_item();
            it.alu = 32'(k);
            drive(it, 1'b1, 1'b1, 1'b0);
            step();
            check("stream_alu", ALU_Result_MEM, k);
            check("stream_valid", mem_valid, 1);
        end
        drive(idle, 1'b0, 1'b1, 1'b0);
        step();

        // Stall with three items offered
        delivered.delete();
        it = rand_item(); it.alu = 32'h10; drive(it, 1'b1, 1'b0, 1'b0); step();
        it = rand_item(); it.alu = 32'h20; drive(it, 1'b1, 1'b0, 1'b0); step();
        it = rand_item(); it.alu = 32'h30; drive(it, 1'b1, 1'b0, 1'b0); step();
        check("stall_ready", ex_ready, 0);
        check("stall_head", ALU_Result_MEM, 32'h10);
        step();
        check("stall_ready2", ex_ready, 0);
        drive(it, 1'b1, 1'b1, 1'b0);
        step();
        step();
        drive(idle, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check("stall_count", delivered.size(), 3);
        for (int i = 0; i < 3; i++)
            check("stall_order", (i < delivered.size()) ? delivered[i] : 32'hDEAD, 32'h10 * (i + 1));

        // Flush while full with a new item offered
        it = rand_item(); it.alu = 32'h61; drive(it, 1'b1, 1'b0, 1'b0); step();
        it = rand_item(); it.alu = 32'h62; drive(it, 1'b1, 1'b0, 1'b0); step();
        check("flush_pre_two", ex_ready, 0);
        it = rand_item(); it.alu = 32'h55; it.ctrl = 5'b11111; drive(it, 1'b1, 1'b0, 1'b1);
        step();
        check("flush_valid", mem_valid, 0);
        check("flush_ctrl", Ctrl_MEM, 0);
        check("flush_ready", ex_ready, 1);
        seen55 = 1'b0;
        drive(idle, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (mem_valid && ALU_Result_MEM == 32'h55) seen55 = 1'b1;
        end
        check("flush_no_55", seen55, 0);

        // Forwarding tap: r0 never forwards
        it = rand_item(); it.ctrl = 5'b10000; it.wr = 5'd0; drive(it, 1'b1, 1'b1, 1'b0); step();
        check("fwd_r0", Fwd_En, 0);
        it = rand_item(); it.ctrl = 5'b10000; it.wr = 5'd5; drive(it, 1'b1, 1'b1, 1'b0); step();
        check("fwd_r5_en", Fwd_En, 1);
        check("fwd_r5_reg", Fwd_Reg, 5);
        drive(idle, 1'b0, 1'b1, 1'b0);
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive(rand_item(), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
            step();
        end

        // Asynchronous reset while full
        drive(rand_item(), 1'b1, 1'b0, 1'b0); step();
        drive(rand_item(), 1'b1, 1'b0, 1'b0); step();
        drive(rand_item(), 1'b1, 1'b0, 1'b0); step();
        check("pre_rst_two", ex_ready, 0);
        #1 Rst_n = 1'b0;
        #1;
        check("arst_valid", mem_valid, 0);
        check("arst_ready", ex_ready, 1);
        check("arst_ctrl", Ctrl_MEM, 0);
        check("arst_fwd", Fwd_En, 0);
        model_q.delete();
        pops_total = 0;
        drive(idle, 1'b0, 1'b1, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            drive(rand_item(), 1'b1, 1'b1, 1'b0);
            step();
        end
        drive(idle, 1'b0, 1'b1, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
